// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage constants: NOP encoding, boot PC, BIOS region bit.
// Also holds the two-state fetch FSM encoding.
package fetch_stage_pkg;

  localparam logic [31:0] INST_NOP     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h4000_0000;
  localparam int          BIOS_BIT     = 30;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_pc_gen.sv
// Next-PC priority mux and the pc_q register for the fetch stage.
// Emits memory word addresses and the region bit of pc_next.
module fetch_pc_gen
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          BIOS_AW  = 12,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_boot,
  input  logic               i_stall,
  input  logic               i_redirect_valid,
  input  logic [31:0]        i_redirect_pc,
  output logic [31:0]        o_pc_q,
  output logic [BIOS_AW-1:0] o_bios_addr,
  output logic [IMEM_AW-1:0] o_imem_addr,
  output logic               o_next_bios
);

  logic [31:0] r_pc_q;
  logic [31:0] w_pc_next;
  logic [31:0] w_redir_pc;

  assign w_redir_pc = i_redirect_pc & 32'hFFFF_FFFC;

  // Redirect beats stall; a stall simply re-reads the current PC.
  always_comb begin
    if (i_boot)
      w_pc_next = RESET_PC;
    else if (i_redirect_valid)
      w_pc_next = w_redir_pc;
    else if (i_stall)
      w_pc_next = r_pc_q;
    else
      w_pc_next = r_pc_q + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_pc_q <= RESET_PC;
    else
      r_pc_q <= w_pc_next;
  end

  assign o_pc_q      = r_pc_q;
  assign o_bios_addr = w_pc_next[BIOS_AW+1:2];
  assign o_imem_addr = w_pc_next[IMEM_AW+1:2];
  assign o_next_bios = w_pc_next[BIOS_BIT];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: boot FSM, BIOS/IMEM enables, data mux, wrong-path kill.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt/flush_cnt counter ports.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          BIOS_AW  = 12,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               bios_en,
  output logic [BIOS_AW-1:0] bios_addr,
  input  logic [31:0]        bios_dout,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_dout,
  output logic [31:0]        id_inst,
  output logic [31:0]        id_pc,
  output logic               id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  fetch_state_e r_state;
  logic         w_boot;
  logic         w_run;
  logic         w_valid;
  logic         w_next_bios;
  logic [31:0]  w_pc_q;
  logic [31:0]  w_mem_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ST_BOOT;
    else
      r_state <= ST_RUN;
  end

  assign w_boot = (r_state == ST_BOOT);
  assign w_run  = (r_state == ST_RUN);

  fetch_pc_gen #(
    .RESET_PC (RESET_PC),
    .BIOS_AW  (BIOS_AW),
    .IMEM_AW  (IMEM_AW)
  ) u_pc_gen (
    .clk              (clk),
    .rst              (rst),
    .i_boot           (w_boot),
    .i_stall          (stall),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_pc_q           (w_pc_q),
    .o_bios_addr      (bios_addr),
    .o_imem_addr      (imem_addr),
    .o_next_bios      (w_next_bios)
  );

  // Boot primes both memories; afterwards only the addressed region reads.
  assign bios_en = w_boot | w_next_bios;
  assign imem_en = w_boot | ~w_next_bios;

  assign w_mem_data = w_pc_q[BIOS_BIT] ? bios_dout : imem_dout;
  assign w_valid    = w_run & ~redirect_valid;

  assign id_valid = w_valid;
  assign id_inst  = w_valid ? w_mem_data : INST_NOP;
  assign id_pc    = w_pc_q;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (w_valid & ~stall)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (w_run & redirect_valid)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage against a PC-sequence reference model.
// Counter checks are included when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        bios_en;
  logic [11:0] bios_addr;
  logic [31:0] bios_dout;
  logic        imem_en;
  logic [13:0] imem_addr;
  logic [31:0] imem_dout;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] bios_mem [0:4095];
  logic [31:0] imem_mem [0:16383];

  // reference model state
  bit          m_run;
  logic [31:0] m_pc;
  logic [31:0] m_fcnt;
  logic [31:0] m_flcnt;
  logic        e_valid;
  logic [31:0] e_inst;
  logic [31:0] e_pc;
  logic [31:0] e_next;
  logic        e_bios_en;
  logic        e_imem_en;
  logic [11:0] e_baddr;
  logic [13:0] e_iaddr;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bios_en        (bios_en),
    .bios_addr      (bios_addr),
    .bios_dout      (bios_dout),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_dout      (imem_dout),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt      (fetch_cnt),
    .flush_cnt      (flush_cnt),
`endif
    .id_valid       (id_valid)
  );

  always @(posedge clk) begin
    if (bios_en) bios_dout <= bios_mem[bios_addr];
    if (imem_en) imem_dout <= imem_mem[imem_addr];
  end

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    if (pc[30]) return bios_mem[pc[13:2]];
    return imem_mem[pc[15:2]];
  endfunction

  task automatic predict;
    e_pc    = m_pc;
    e_valid = m_run && !redirect_valid;
    e_inst  = e_valid ? mem_word(m_pc) : NOP;
    if (!m_run) e_next = RST_PC;
    else if (redirect_valid) e_next = redirect_pc & 32'hFFFF_FFFC;
    else if (stall) e_next = m_pc;
    else e_next = m_pc + 32'd4;
    e_bios_en = !m_run || e_next[30];
    e_imem_en = !m_run || !e_next[30];
    e_baddr   = e_next[13:2];
    e_iaddr   = e_next[15:2];
  endtask

  task automatic model_reset;
    m_run = 0; m_pc = RST_PC; m_fcnt = 0; m_flcnt = 0;
  endtask

  task automatic drive(input logic st, input logic rv, input logic [31:0] rp);
    @(negedge clk);
    stall = st; redirect_valid = rv; redirect_pc = rp;
    #1;
    predict();
  endtask

  task automatic tick;
    @(posedge clk);
    if (!rst) begin
      if (m_run && !redirect_valid && !stall) m_fcnt = m_fcnt + 1;
      if (m_run && redirect_valid) m_flcnt = m_flcnt + 1;
      m_pc  = e_next;
      m_run = 1;
    end
  endtask

  task automatic test_reset;
    rst = 1; stall = 0; redirect_valid = 0; redirect_pc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", id_valid); end
    checks++;
    if (id_inst !== NOP) begin failures++; $display("FAIL rst_inst got=%h exp=%h", id_inst, NOP); end
    checks++;
    if (id_pc !== RST_PC) begin failures++; $display("FAIL rst_pc got=%h exp=%h", id_pc, RST_PC); end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (fetch_cnt !== 0 || flush_cnt !== 0) begin
      failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", fetch_cnt, flush_cnt);
    end
`endif
  endtask

  task automatic test_boot;
    @(negedge clk); rst = 0; #1; predict();
    checks++;
    if (bios_addr !== 12'd0) begin failures++; $display("FAIL boot_addr got=%0d exp=0", bios_addr); end
    checks++;
    if (id_valid !== 1'b0) begin failures++; $display("FAIL boot_valid got=%b exp=0", id_valid); end
    checks++;
    if (bios_en !== 1'b1 || imem_en !== 1'b1) begin
      failures++; $display("FAIL boot_en got=%b%b exp=11", bios_en, imem_en);
    end
    tick();
    drive(0, 0, 0);
    checks++;
    if (id_inst !== 32'h0000_0093) begin failures++; $display("FAIL boot_inst got=%h exp=00000093", id_inst); end
    checks++;
    if (id_pc !== RST_PC || id_valid !== 1'b1) begin
      failures++; $display("FAIL boot_pc got=%h/%b exp=%h/1", id_pc, id_valid, RST_PC);
    end
    tick();
    drive(0, 0, 0);
    checks++;
    if (id_pc !== 32'h4000_0004) begin failures++; $display("FAIL boot_pc2 got=%h exp=40000004", id_pc); end
    tick();
  endtask

  task automatic test_stall;
    logic [31:0] held;
    held = bios_mem[2];
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0);
      checks++;
      if (id_pc !== 32'h4000_0008 || id_inst !== held || id_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold%0d got=%h/%h exp=40000008/%h", i, id_pc, id_inst, held);
      end
      checks++;
      if (bios_addr !== 12'd2) begin failures++; $display("FAIL stall_addr%0d got=%0d exp=2", i, bios_addr); end
      tick();
    end
    drive(0, 0, 0);
    tick();
    drive(0, 0, 0);
    checks++;
    if (id_pc !== 32'h4000_000C) begin failures++; $display("FAIL stall_rel got=%h exp=4000000c", id_pc); end
    tick();
  endtask

  task automatic test_redirect;
    drive(0, 1, 32'h0000_0103);
    checks++;
    if (id_valid !== 1'b0 || id_inst !== NOP) begin
      failures++; $display("FAIL redir_kill got=%b/%h exp=0/%h", id_valid, id_inst, NOP);
    end
    checks++;
    if (imem_en !== 1'b1 || bios_en !== 1'b0 || imem_addr !== 14'd64) begin
      failures++; $display("FAIL redir_addr got=%b%b/%0d exp=01/64", bios_en, imem_en, imem_addr);
    end
    tick();
    drive(0, 0, 0);
    checks++;
    if (id_pc !== 32'h0000_0100 || id_valid !== 1'b1 || id_inst !== imem_mem[64]) begin
      failures++; $display("FAIL redir_tgt got=%h/%b/%h exp=00000100/1/%h", id_pc, id_valid, id_inst, imem_mem[64]);
    end
    tick();
  endtask

  task automatic test_redirect_stall;
    drive(1, 1, 32'h4000_0020);
    checks++;
    if (id_valid !== 1'b0) begin failures++; $display("FAIL rs_kill got=%b exp=0", id_valid); end
    tick();
    drive(0, 0, 0);
    checks++;
    if (id_pc !== 32'h4000_0020 || id_valid !== 1'b1) begin
      failures++; $display("FAIL rs_tgt got=%h/%b exp=40000020/1", id_pc, id_valid);
    end
    tick();
  endtask

  task automatic test_wrap;
    drive(0, 1, 32'hFFFF_FFFF);
    tick();
    drive(0, 0, 0);
    checks++;
    if (id_pc !== 32'hFFFF_FFFC || id_inst !== bios_mem[4095]) begin
      failures++; $display("FAIL wrap_top got=%h/%h exp=fffffffc/%h", id_pc, id_inst, bios_mem[4095]);
    end
    tick();
    drive(0, 0, 0);
    checks++;
    if (id_pc !== 32'h0000_0000 || id_inst !== imem_mem[0]) begin
      failures++; $display("FAIL wrap_zero got=%h/%h exp=00000000/%h", id_pc, id_inst, imem_mem[0]);
    end
    tick();
  endtask

  task automatic test_random;
    logic st, rv;
    logic [31:0] rp;
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 9) == 0);
      rp = $urandom();
      drive(st, rv, rp);
      checks++;
      if (id_valid !== e_valid || id_pc !== e_pc || id_inst !== e_inst) begin
        failures++;
        $display("FAIL rnd_out%0d got=%b/%h/%h exp=%b/%h/%h", i, id_valid, id_pc, id_inst, e_valid, e_pc, e_inst);
      end
      checks++;
      if (bios_en !== e_bios_en || imem_en !== e_imem_en ||
          bios_addr !== e_baddr || imem_addr !== e_iaddr) begin
        failures++;
        $display("FAIL rnd_mem%0d got=%b%b/%h/%h exp=%b%b/%h/%h", i, bios_en, imem_en,
                 bios_addr, imem_addr, e_bios_en, e_imem_en, e_baddr, e_iaddr);
      end
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (fetch_cnt !== m_fcnt || flush_cnt !== m_flcnt) begin
        failures++;
        $display("FAIL rnd_cnt%0d got=%0d/%0d exp=%0d/%0d", i, fetch_cnt, flush_cnt, m_fcnt, m_flcnt);
      end
`endif
      tick();
    end
  endtask

  task automatic test_mid_reset;
    drive(0, 1, 32'h0000_0200);
    tick();
    drive(0, 0, 0);
    checks++;
    if (id_pc !== 32'h0000_0200 || id_valid !== 1'b1) begin
      failures++; $display("FAIL mr_pre got=%h/%b exp=00000200/1", id_pc, id_valid);
    end
    #1 rst = 1;
    #1;
    model_reset();
    checks++;
    if (id_valid !== 1'b0 || id_inst !== NOP || id_pc !== RST_PC) begin
      failures++; $display("FAIL mr_async got=%b/%h/%h exp=0/%h/%h", id_valid, id_inst, id_pc, NOP, RST_PC);
    end
    @(posedge clk);
    @(negedge clk); rst = 0; #1; predict();
    checks++;
    if (id_valid !== 1'b0 || bios_addr !== 12'd0 || bios_en !== 1'b1) begin
      failures++; $display("FAIL mr_boot got=%b/%0d/%b exp=0/0/1", id_valid, bios_addr, bios_en);
    end
    tick();
    drive(0, 0, 0);
    checks++;
    if (id_pc !== RST_PC || id_valid !== 1'b1 || id_inst !== 32'h0000_0093) begin
      failures++; $display("FAIL mr_restart got=%h/%b/%h exp=%h/1/00000093", id_pc, id_valid, id_inst, RST_PC);
    end
    tick();
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_counters;
    @(negedge clk); rst = 1; stall = 0; redirect_valid = 0; #1;
    model_reset();
    @(negedge clk); rst = 0; #1; predict();
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0);
      tick();
    end
    drive(0, 1, 32'h4000_0100); tick();
    drive(0, 1, 32'h0000_0040); tick();
    drive(0, 0, 0);
    checks++;
    if (fetch_cnt !== 32'd10 || flush_cnt !== 32'd2) begin
      failures++; $display("FAIL cnt_final got=%0d/%0d exp=10/2", fetch_cnt, flush_cnt);
    end
    tick();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) bios_mem[i] = $urandom();
    for (int i = 0; i < 16384; i++) imem_mem[i] = $urandom();
    bios_mem[0] = 32'h0000_0093;
    test_reset();
    test_boot();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_random();
    test_mid_reset();
`ifdef FETCH_PERF_CNT_EN
    test_counters();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
